lease_buffer_reader: RTL and testbench

LEASE_BUFFER_READER -- requirements
Module: lease_buffer_reader

---
 rtl/lease_buffer_reader.sv | 153 +++++++++++++++
 tb/tb_lease_buffer_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lease_buffer_reader.sv
// Drains sampler lease records from the buffer and streams them out as 32-bit words.
// Define LEASE_READER_TARGET_EN to append the target word (5 words/record instead of 4).
module lease_buffer_reader #(
    parameter int unsigned N_RECORD_MAX = 8192
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        full_i,
    input  logic [31:0] used_i,
    output logic [12:0] buf_add_o,
    input  logic [31:0] buf_pc_i,
    input  logic [31:0] buf_interval_i,
    input  logic [63:0] buf_trace_i,
    input  logic [31:0] buf_target_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        clear_o,
    output logic        busy_o,
    output logic [31:0] records_sent_o
);

    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TRACE_W = 64;
    localparam int unsigned SEL_W   = 3;
`ifdef LEASE_READER_TARGET_EN
    localparam int unsigned WORDS   = 5;
`else
    localparam int unsigned WORDS   = 4;
`endif
    localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(WORDS - 1);
    localparam logic [DATA_W-1:0] N_MAX    = DATA_W'(N_RECORD_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        LOAD  = 3'd3,
        SEND  = 3'd4,
        CLEAR = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]  n_q, index_q;
    logic [DATA_W-1:0]  n_cap_c, index_inc_c;
    logic [SEL_W-1:0]   word_sel_q, sel_inc_c;
    logic [DATA_W-1:0]  hold_interval_q, hold_target_q;
    logic [TRACE_W-1:0] hold_trace_q;
    logic [DATA_W-1:0]  word_next_c;
    logic               go_c, xfer_c, last_c;

    // State register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and per-cycle strobes
    always_comb begin
        state_d     = state_q;
        go_c        = 1'b0;
        xfer_c      = 1'b0;
        last_c      = 1'b0;
        n_cap_c     = (used_i > N_MAX) ? N_MAX : used_i;
        index_inc_c = index_q + DATA_W'(1);
        sel_inc_c   = word_sel_q + SEL_W'(1);

        case (sel_inc_c)
            SEL_W'(1): word_next_c = hold_interval_q;
            SEL_W'(2): word_next_c = hold_trace_q[31:0];
            SEL_W'(3): word_next_c = hold_trace_q[63:32];
            default:   word_next_c = hold_target_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start_i || full_i) begin
                    go_c    = 1'b1;
                    state_d = (n_cap_c == '0) ? CLEAR : ADDR;
                end
            end
            ADDR: state_d = WAIT;
            WAIT: state_d = LOAD;
            LOAD: state_d = SEND;
            SEND: begin
                if (word_ready_i) begin
                    xfer_c = 1'b1;
                    if (word_sel_q == LAST_SEL) begin
                        last_c  = 1'b1;
                        state_d = (index_inc_c < n_q) ? ADDR : CLEAR;
                    end
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs; clear_o follows the CLEAR state by one cycle
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            n_q             <= '0;
            index_q         <= '0;
            word_sel_q      <= '0;
            hold_interval_q <= '0;
            hold_trace_q    <= '0;
            hold_target_q   <= '0;
            buf_add_o       <= '0;
            word_o          <= '0;
            word_valid_o    <= 1'b0;
            clear_o         <= 1'b0;
            busy_o          <= 1'b0;
            records_sent_o  <= '0;
        end else begin
            clear_o <= (state_q == CLEAR);
            busy_o  <= (state_d != IDLE);

            if (go_c) begin
                n_q     <= n_cap_c;
                index_q <= '0;
            end

            // Address is presented for the whole ADDR cycle and held afterwards
            if (state_d == ADDR) begin
                buf_add_o <= (state_q == IDLE) ? ADDR_W'(0) : index_inc_c[ADDR_W-1:0];
            end

            if (state_q == LOAD) begin
                hold_interval_q <= buf_interval_i;
                hold_trace_q    <= buf_trace_i;
                hold_target_q   <= buf_target_i;
                word_o          <= buf_pc_i;
                word_valid_o    <= 1'b1;
                word_sel_q      <= '0;
            end

            if (xfer_c) begin
                if (last_c) begin
                    word_valid_o   <= 1'b0;
                    records_sent_o <= records_sent_o + DATA_W'(1);
                    index_q        <= index_inc_c;
                end else begin
                    word_sel_q <= sel_inc_c;
                    word_o     <= word_next_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_lease_buffer_reader.sv
// Self-checking bench for lease_buffer_reader: table-driven drains with a word scoreboard,
// plus hand sequences for empty-drain timing, mid-record reset and back-to-back drains.
module tb_lease_buffer_reader;

`ifdef LEASE_READER_TARGET_EN
    localparam int unsigned WPR = 5;
`else
    localparam int unsigned WPR = 4;
`endif
    localparam int unsigned NMAX = 8192;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        full  = 1'b0;
    logic [31:0] used  = '0;
    logic        word_ready = 1'b1;
    logic [12:0] buf_add;
    logic [31:0] buf_pc = '0, buf_interval = '0, buf_target = '0;
    logic [63:0] buf_trace = '0;
    logic [31:0] word;
    logic        word_valid, clear, busy;
    logic [31:0] records_sent;

    lease_buffer_reader dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .start_i        (start),
        .full_i         (full),
        .used_i         (used),
        .buf_add_o      (buf_add),
        .buf_pc_i       (buf_pc),
        .buf_interval_i (buf_interval),
        .buf_trace_i    (buf_trace),
        .buf_target_i   (buf_target),
        .word_o         (word),
        .word_valid_o   (word_valid),
        .word_ready_i   (word_ready),
        .clear_o        (clear),
        .busy_o         (busy),
        .records_sent_o (records_sent)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] f_pc(input int unsigned a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction
    function automatic logic [31:0] f_int(input int unsigned a);
        return 32'h1000_0000 + 32'(a) * 32'd7;
    endfunction
    function automatic logic [63:0] f_trace(input int unsigned a);
        return {32'h7ACE_0000 ^ 32'(a), 32'h3000_0000 + 32'(a) * 32'd3};
    endfunction
    function automatic logic [31:0] f_tgt(input int unsigned a);
        return 32'h7A60_0000 | 32'(a);
    endfunction
    function automatic logic [31:0] exp_word(input int unsigned r, input int unsigned k);
        logic [63:0] t;
        t = f_trace(r);
        case (k)
            0:       return f_pc(r);
            1:       return f_int(r);
            2:       return t[31:0];
            3:       return t[63:32];
            default: return f_tgt(r);
        endcase
    endfunction

    // Buffer model: one-cycle read latency
    always @(posedge clock) begin
        buf_pc       <= f_pc(32'(buf_add));
        buf_interval <= f_int(32'(buf_add));
        buf_trace    <= f_trace(32'(buf_add));
        buf_target   <= f_tgt(32'(buf_add));
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready driver: mode 0 always ready, mode 1 repeats 1,0,0,1
    int unsigned ready_mode = 0;
    int unsigned rcyc = 0;
    always @(posedge clock) begin
        #1;
        rcyc++;
        word_ready = (ready_mode == 0) ? 1'b1 : ((rcyc % 4 == 0) || (rcyc % 4 == 3));
    end

    // Scoreboard monitor
    logic [31:0] sb_q[$];
    int unsigned xfer_cnt = 0, clear_cnt = 0, valid_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = '0;
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(word_valid), 64'd1);
                chk("stall_word", 64'(word), 64'(prev_word));
            end
            if (word_valid) valid_cnt++;
            if (clear) clear_cnt++;
            if (word_valid && word_ready) begin
                xfer_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %0h expected none at %0t", word, $time);
                end else begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    if (word !== e) begin
                        errors++;
                        $display("FAIL word: got %0h expected %0h at %0t", word, e, $time);
                    end
                end
            end
            prev_stall = word_valid && !word_ready;
            prev_word  = word;
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_buf_add"}, 64'(buf_add), 64'd0);
        chk({tag, "_word"}, 64'(word), 64'd0);
        chk({tag, "_valid"}, 64'(word_valid), 64'd0);
        chk({tag, "_clear"}, 64'(clear), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_sent"}, 64'(records_sent), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #1 reset = 1'b1; start = 1'b0; full = 1'b0;
        @(negedge clock);
        check_zero_outputs("reset");
        @(posedge clock);
        #1 reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic kick(input logic [31:0] u, input bit via_full);
        int unsigned n;
        n = (u > NMAX) ? NMAX : int'(u);
        @(posedge clock);
        #1 used = u;
        if (via_full) full = 1'b1;
        else          start = 1'b1;
        for (int r = 0; r < int'(n); r++)
            for (int k = 0; k < int'(WPR); k++)
                sb_q.push_back(exp_word(r, k));
        @(posedge clock);
        #1 start = 1'b0; full = 1'b0;
    endtask

    task automatic wait_clear(input int unsigned budget, input int unsigned c0);
        int unsigned i;
        i = 0;
        while (clear_cnt == c0 && i < budget) begin
            @(negedge clock);
            #1;
            i++;
        end
        chk("drain_done", 64'(clear_cnt - c0), 64'd1);
    endtask

    typedef struct {
        logic [31:0] used;
        bit          via_full;
        int unsigned rmode;
        bit          poke;
        int unsigned exp_recs;
    } vec_t;

    vec_t tv[6];

    initial begin
        int unsigned c0, x0, v0;
        automatic int watchdog_unused = 0;

        tv[0] = '{32'd2,    1'b0, 0, 1'b0, 2};
        tv[1] = '{32'd1,    1'b0, 1, 1'b0, 1};
        tv[2] = '{32'd0,    1'b0, 0, 1'b0, 0};
        tv[3] = '{32'd3,    1'b0, 1, 1'b1, 3};
        tv[4] = '{32'd5,    1'b1, 0, 1'b0, 5};
        tv[5] = '{32'd8192, 1'b1, 0, 1'b0, 8192};

        for (int i = 0; i < 6; i++) begin
            apply_reset();
            ready_mode = tv[i].rmode;
            c0 = clear_cnt; x0 = xfer_cnt; v0 = valid_cnt;
            kick(tv[i].used, tv[i].via_full);
            if (tv[i].poke) begin
                // Requests and used_i changes while busy must be ignored
                repeat (6) @(posedge clock);
                #1 start = 1'b1; full = 1'b1; used = 32'd7;
                @(posedge clock);
                #1 start = 1'b0; full = 1'b0;
            end
            wait_clear(tv[i].exp_recs * (WPR * 4 + 8) + 40, c0);
            repeat (3) @(negedge clock);
            chk("words", 64'(xfer_cnt - x0), 64'(tv[i].exp_recs * WPR));
            chk("records_sent", 64'(records_sent), 64'(tv[i].exp_recs));
            chk("clear_pulses", 64'(clear_cnt - c0), 64'd1);
            chk("sb_empty", 64'(sb_q.size()), 64'd0);
            chk("busy_after", 64'(busy), 64'd0);
            if (tv[i].exp_recs == 0) chk("no_valid", 64'(valid_cnt - v0), 64'd0);
            if (tv[i].exp_recs == NMAX) chk("last_addr", 64'(buf_add), 64'd8191);
        end

        // Empty drain: clear_o two cycles after the start pulse
        apply_reset();
        ready_mode = 0;
        @(posedge clock);
        #1 used = 32'd0; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk("empty_clear_c1", 64'(clear), 64'd0);
        chk("empty_busy_c1", 64'(busy), 64'd1);
        @(negedge clock);
        chk("empty_clear_c2", 64'(clear), 64'd1);
        @(negedge clock);
        chk("empty_clear_c3", 64'(clear), 64'd0);
        chk("empty_busy_c3", 64'(busy), 64'd0);

        // Reset during the third word of a record, then restart
        apply_reset();
        ready_mode = 0;
        x0 = xfer_cnt;
        kick(32'd1, 1'b0);
        for (int i = 0; i < 40 && (xfer_cnt - x0) < 2; i++) begin
            @(negedge clock);
            #1;
        end
        chk("pre_reset_xfers", 64'(xfer_cnt - x0), 64'd2);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_zero_outputs("async_reset");
        @(posedge clock);
        #1 reset = 1'b0;
        sb_q.delete();
        c0 = clear_cnt; x0 = xfer_cnt;
        kick(32'd1, 1'b0);
        wait_clear(100, c0);
        repeat (2) @(negedge clock);
        chk("restart_words", 64'(xfer_cnt - x0), 64'(WPR));
        chk("restart_sent", 64'(records_sent), 64'd1);
        chk("restart_sb_empty", 64'(sb_q.size()), 64'd0);

        // Back-to-back drains without reset accumulate records_sent
        apply_reset();
        ready_mode = 1;
        c0 = clear_cnt;
        kick(32'd1, 1'b0);
        wait_clear(100, c0);
        c0 = clear_cnt;
        kick(32'd2, 1'b1);
        wait_clear(200, c0);
        repeat (2) @(negedge clock);
        chk("b2b_sent", 64'(records_sent), 64'd3);
        chk("b2b_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors + watchdog_unused);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
